sys_bus_arbiter: RTL

// Owns the shared system bus (Address/DataOut/RAM Cs/Wena/Oen) between CPU and DMA.
// CPU is default owner. DMA gets the bus through Bus_req/Bus_grant only at a CPU-free point.
// DMA tenure is bounded by a hold limit when the CPU is waiting.

---
 rtl/sys_bus_pkg.sv | 25 ++
 rtl/sys_bus_mux.sv | 62 ++++++
 rtl/sys_bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the CPU/DMA system bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sys_bus_pkg;

    // Bus ownership FSM states
    typedef enum logic [2:0] {
        CPU_OWN,
        TURN_DMA,
        DMA_OWN,
        DRAIN,
        TURN_CPU
    } bus_state_t;

    // RAM control levels driven while nobody owns the bus (all active-high)
    localparam logic IDLE_CS   = 1'b0;
    localparam logic IDLE_WENA = 1'b0;
    localparam logic IDLE_OEN  = 1'b0;

    // Width of a counter that must hold values 0..n (minimum 1 bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sys_bus_mux.sv
// 2:1 system bus mux (CPU/DMA) with idle forcing during turnaround states.
// Latency: purely combinational from the registered state and the source buses.
// Backpressure: none; the FSM decides ownership, this block only steers.
// Ports: i_state selects the source; i_cpu_* / i_dma_* are the two master buses;
//        o_* is the shared system bus toward the RAM.
module sys_bus_mux
    import sys_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  bus_state_t        i_state,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_wena,
    input  logic              i_cpu_oen,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_dat,
    input  logic              i_dma_cs,
    input  logic              i_dma_wena,
    input  logic              i_dma_oen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_cs,
    output logic              o_wena,
    output logic              o_oen
);

    always_comb begin
        o_addr = '0;
        o_dat  = '0;
        o_cs   = IDLE_CS;
        o_wena = IDLE_WENA;
        o_oen  = IDLE_OEN;
        case (i_state)
            CPU_OWN: begin
                o_addr = i_cpu_addr;
                o_dat  = i_cpu_dat;
                o_cs   = i_cpu_cs;
                o_wena = i_cpu_wena;
                o_oen  = i_cpu_oen;
            end
            // DRAIN keeps the DMA bus so an access already in flight can finish
            DMA_OWN, DRAIN: begin
                o_addr = i_dma_addr;
                o_dat  = i_dma_dat;
                o_cs   = i_dma_cs;
                o_wena = i_dma_wena;
                o_oen  = i_dma_oen;
            end
            default: begin
                o_addr = '0;
                o_dat  = '0;
                o_cs   = IDLE_CS;
                o_wena = IDLE_WENA;
                o_oen  = IDLE_OEN;
            end
        endcase
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// CPU/DMA system bus arbiter: CPU default owner, DMA via Bus_req/Bus_grant handshake.
// Latency: request taken at cycle N -> idle turnaround N+1 -> Bus_grant and DMA bus at N+2.
// Backpressure: DMA held off while CPU busy or in cooldown; DMA tenure preempted after
//               MAX_HOLD cycles of CPU waiting (0 disables).
// Ports: Clk/Rst (sync, active-high); Cpu_* CPU bus and status; Bus_req/Dma_* DMA side;
//        Bus_grant, Preempted and the muxed system bus (Address/DataOut/Cs/Wena/Oen).
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Cpu_Bus_Free,
    input  logic              Cpu_Req,
    input  logic [ADDR_W-1:0] Cpu_Address,
    input  logic [DATA_W-1:0] Cpu_DataOut,
    input  logic              Cpu_Cs,
    input  logic              Cpu_Wena,
    input  logic              Cpu_Oen,
    input  logic              Bus_req,
    input  logic [ADDR_W-1:0] Dma_Address,
    input  logic [DATA_W-1:0] Dma_DataOut,
    input  logic              Dma_Cs,
    input  logic              Dma_Wena,
    input  logic              Dma_Oen,
    output logic              Bus_grant,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataOut,
    output logic              Cs,
    output logic              Wena,
    output logic              Oen,
    output logic              Preempted
);

    localparam int unsigned HOLD_W = cnt_width(MAX_HOLD);
    localparam int unsigned COOL_W = cnt_width(COOLDOWN);

    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    // Only meaningful when MAX_HOLD != 0; the hit test is gated accordingly
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

    bus_state_t        r_state;
    bus_state_t        w_next_state;
    logic              r_bus_grant;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [COOL_W-1:0] r_cool_cnt;
    logic              w_hold_hit;
    logic              w_preempted;

    // Last permitted DMA cycle while the CPU is stalled waiting
    assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && Cpu_Req;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= CPU_OWN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CPU_OWN: begin
                if (Bus_req && Cpu_Bus_Free && (r_cool_cnt == '0)) begin
                    w_next_state = TURN_DMA;
                end
            end
            TURN_DMA: w_next_state = DMA_OWN;
            DMA_OWN: begin
                // A voluntary release takes priority over preemption
                if (!Bus_req) begin
                    w_next_state = TURN_CPU;
                end else if (w_hold_hit) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!Dma_Cs) begin
                    w_next_state = TURN_CPU;
                end
            end
            TURN_CPU: w_next_state = CPU_OWN;
            default:  w_next_state = CPU_OWN;
        endcase
    end

    // Outputs: Preempted marks the DMA_OWN cycle that decides to cut the tenure
    always_comb begin
        w_preempted = 1'b0;
        if ((r_state == DMA_OWN) && Bus_req && w_hold_hit) begin
            w_preempted = 1'b1;
        end
    end

    // Grant is a flop loaded from the next state, so Bus_req never reaches it combinationally
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_bus_grant <= 1'b0;
        end else begin
            r_bus_grant <= (w_next_state == DMA_OWN);
        end
    end

    // Hold counter: DMA cycles spent while the CPU is waiting, saturating
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hold_cnt <= '0;
        end else if (r_state == TURN_DMA) begin
            r_hold_cnt <= '0;
        end else if ((r_state == DMA_OWN) && Cpu_Req && (r_hold_cnt != HOLD_SAT)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // Cooldown counter: loaded on leaving DRAIN, runs down only while the CPU owns the bus
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cool_cnt <= '0;
        end else if ((r_state == DRAIN) && !Dma_Cs) begin
            r_cool_cnt <= COOL_LOAD;
        end else if ((r_state == CPU_OWN) && (r_cool_cnt != '0)) begin
            r_cool_cnt <= r_cool_cnt - COOL_W'(1);
        end
    end

    assign Bus_grant = r_bus_grant;
    assign Preempted = w_preempted;

    sys_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_state    (r_state),
        .i_cpu_addr (Cpu_Address),
        .i_cpu_dat  (Cpu_DataOut),
        .i_cpu_cs   (Cpu_Cs),
        .i_cpu_wena (Cpu_Wena),
        .i_cpu_oen  (Cpu_Oen),
        .i_dma_addr (Dma_Address),
        .i_dma_dat  (Dma_DataOut),
        .i_dma_cs   (Dma_Cs),
        .i_dma_wena (Dma_Wena),
        .i_dma_oen  (Dma_Oen),
        .o_addr     (Address),
        .o_dat      (DataOut),
        .o_cs       (Cs),
        .o_wena     (Wena),
        .o_oen      (Oen)
    );

endmodule
